spi_master_ram_if: RTL and testbench

SPI_MASTER_RAM_IF -- requirements
Module: spi_master_ram_if

---
 rtl/spi_master_ram_if.sv | 124 ++++++++++++
 tb/tb_spi_master_ram_if.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ram_if.sv
// SPI master framing {cmd[1:0], payload[7:0]} to a slave-side RAM; read-data frames
// wait RD_LAT cycles, then capture a byte from MISO. Optional `SPI_MASTER_ERR_EN adds sticky err.
module spi_master_ram_if #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO
`ifdef SPI_MASTER_ERR_EN
  , output logic     err
`endif
);

  typedef enum logic [2:0] {IDLE, SHIFT_OUT, WAIT_RD, SHIFT_IN, FINISH} state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(RD_LAT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [8:0] r_frame;   // remaining frame bits; bit 9 goes straight to MOSI on accept
  logic       r_rd;
  logic [7:0] r_shift;
  logic [7:0] r_rdata;
  logic       r_done;
  logic       r_mosi;
  logic       r_ss_n;
`ifdef SPI_MASTER_ERR_EN
  logic       r_err;
  assign err = r_err;
`endif

  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign rdata = r_rdata;
  assign MOSI  = r_mosi;
  assign SS_n  = r_ss_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_frame <= 9'd0;
      r_rd    <= 1'b0;
      r_shift <= 8'h00;
      r_rdata <= 8'h00;
      r_done  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss_n  <= 1'b1;
`ifdef SPI_MASTER_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SPI_MASTER_ERR_EN
      if (start && r_state != IDLE) r_err <= 1'b1;
`endif
      case (r_state)
        IDLE: begin
          if (start) begin
            r_frame <= {cmd[0], (cmd == 2'b11) ? 8'h00 : wdata};
            r_rd    <= (cmd == 2'b11);
            r_mosi  <= cmd[1];
            r_ss_n  <= 1'b0;
            r_cnt   <= 4'd9;
            r_state <= SHIFT_OUT;
`ifdef SPI_MASTER_ERR_EN
            r_err   <= 1'b0;
`endif
          end
        end
        SHIFT_OUT: begin
          if (r_cnt == 4'd0) begin
            r_mosi <= 1'b0;
            if (r_rd) begin
              r_cnt   <= LP_WAIT_LAST;
              r_state <= WAIT_RD;
            end else begin
              r_ss_n  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end
          end else begin
            r_mosi  <= r_frame[8];
            r_frame <= {r_frame[7:0], 1'b0};
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        WAIT_RD: begin
          if (r_cnt == 4'd0) begin
            r_cnt   <= 4'd7;
            r_state <= SHIFT_IN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        SHIFT_IN: begin
          r_shift <= {r_shift[6:0], MISO};
          if (r_cnt == 4'd0) begin
            r_rdata <= {r_shift[6:0], MISO};
            r_ss_n  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        FINISH: begin
          r_cnt   <= 4'd0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ram_if.sv
// Table-driven bench for spi_master_ram_if with a behavioural SPI slave + RAM on the bus
// and a queue of expected read bytes popped on each done pulse.
module tb_spi_master_ram_if;
  localparam int RD_LAT = 2;

  logic       clk = 1'b0;
  logic       rst, start, MISO;
  logic [1:0] cmd;
  logic [7:0] wdata;
  wire        busy, done, MOSI, SS_n;
  wire  [7:0] rdata;
`ifdef SPI_MASTER_ERR_EN
  wire        err;
`endif

  spi_master_ram_if #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .MOSI(MOSI), .SS_n(SS_n),
    .MISO(MISO)
`ifdef SPI_MASTER_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: captures 10 MOSI bits, then serves the addressed RAM byte after RD_LAT idle cycles.
  logic [7:0] s_mem [256];
  logic [7:0] s_addr = 8'h00;
  logic [9:0] s_sh = 10'd0;
  logic [7:0] s_rbyte = 8'h00;
  int         s_k = 0;

  initial MISO = 1'b0;

  always @(negedge clk) begin
    if (SS_n !== 1'b0) begin
      s_k  = 0;
      MISO = 1'b0;
    end else begin
      s_k++;
      if (s_k <= 10) s_sh = {s_sh[8:0], MOSI};
      if (s_k == 10) begin
        case (s_sh[9:8])
          2'b00:   s_addr = s_sh[7:0];
          2'b01:   s_mem[s_addr] = s_sh[7:0];
          2'b10:   s_addr = s_sh[7:0];
          default: s_rbyte = s_mem[s_addr];
        endcase
      end
      if (s_k >= 11 + RD_LAT && s_k <= 18 + RD_LAT) MISO = s_rbyte[7 - (s_k - 11 - RD_LAT)];
      else MISO = 1'b0;
    end
  end

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] wdata;
    int         pulse_at;   // cycle after T at which a stray start is pulsed (0 = none)
    logic [7:0] exp_rdata;
    int         exp_lat;
  } rec_t;

  rec_t       tbl [12];
  logic [7:0] exp_q [$];

  task automatic run_frame(input rec_t r);
    int         lat;
    logic [9:0] mosi_seen, exp_frame;
    bit         ss_ok, busy_ok;
    logic [7:0] exp_rd;
    exp_frame = {r.cmd, (r.cmd == 2'b11) ? 8'h00 : r.wdata};
    @(negedge clk);
    start = 1'b1; cmd = r.cmd; wdata = r.wdata;
    exp_q.push_back(r.exp_rdata);
    @(negedge clk);
    start = 1'b0; cmd = 2'($urandom); wdata = 8'($urandom);
`ifdef SPI_MASTER_ERR_EN
    chk("err_clear_on_accept", err, 1'b0);
`endif
    lat = 0; mosi_seen = 10'd0; ss_ok = 1'b1; busy_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (i <= 10) begin
        mosi_seen = {mosi_seen[8:0], MOSI};
        if (SS_n !== 1'b0) ss_ok = 1'b0;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = (i == r.pulse_at);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk("mosi_frame", mosi_seen, exp_frame);
    chk("ss_low_shift", ss_ok, 1'b1);
    chk("busy_in_frame", busy_ok, 1'b1);
    chk("done_latency", lat, r.exp_lat);
    chk("rdata", rdata, exp_rd);
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_busy", busy, 1'b0);
    chk("idle_after_ssn", SS_n, 1'b1);
    chk("done_one_cycle", done, 1'b0);
`ifdef SPI_MASTER_ERR_EN
    chk("err_sticky", err, (r.pulse_at != 0));
`endif
    @(negedge clk);
    chk("no_queued_frame", busy, 1'b0);
  endtask

  initial begin
    int ndone, nruns, hrun;
    bit seen_low, done_seen;

    tbl[0]  = '{2'b00, 8'hA5, 0,  8'h00, 11};
    tbl[1]  = '{2'b00, 8'h10, 0,  8'h00, 11};
    tbl[2]  = '{2'b01, 8'h3C, 5,  8'h00, 11};
    tbl[3]  = '{2'b10, 8'h10, 11, 8'h00, 11};
    tbl[4]  = '{2'b11, 8'h77, 0,  8'h3C, 19 + RD_LAT};
    tbl[5]  = '{2'b00, 8'h20, 0,  8'h3C, 11};
    tbl[6]  = '{2'b01, 8'hFF, 0,  8'h3C, 11};
    tbl[7]  = '{2'b11, 8'h00, 0,  8'hFF, 19 + RD_LAT};
    tbl[8]  = '{2'b10, 8'h20, 0,  8'hFF, 11};
    tbl[9]  = '{2'b01, 8'h00, 0,  8'hFF, 11};
    tbl[10] = '{2'b10, 8'h20, 0,  8'hFF, 11};
    tbl[11] = '{2'b11, 8'h5A, 0,  8'h00, 19 + RD_LAT};

    for (int a = 0; a < 256; a++) s_mem[a] = 8'h00;
    rst = 1'b1; start = 1'b0; cmd = 2'b00; wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ssn", SS_n, 1'b1);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
`ifdef SPI_MASTER_ERR_EN
    chk("rst_err", err, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 12; t++) run_frame(tbl[t]);

    // Start held high: frames must be separated by FINISH + one IDLE cycle.
    @(negedge clk);
    start = 1'b1; cmd = 2'b00; wdata = 8'h5A;
    ndone = 0; nruns = 0; hrun = 0; seen_low = 1'b0;
    for (int j = 0; j < 45; j++) begin
      if (done === 1'b1) ndone++;
      if (SS_n === 1'b0) begin
        if (seen_low && hrun > 0) begin
          nruns++;
          chk("b2b_gap", hrun, 2);
        end
        seen_low = 1'b1;
        hrun = 0;
      end else if (seen_low) begin
        hrun++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_done_count", ndone, 3);
    chk("b2b_gap_count", nruns, 3);
    done_seen = 1'b0;
    for (int j = 0; j < 30 && busy === 1'b1; j++) @(negedge clk);
    chk("b2b_drain", busy, 1'b0);

    // Reset in the middle of a read-data frame.
    run_frame('{2'b00, 8'h30, 0, 8'h00, 11});
    run_frame('{2'b01, 8'hC3, 0, 8'h00, 11});
    run_frame('{2'b11, 8'h00, 0, 8'hC3, 19 + RD_LAT});
    @(negedge clk);
    start = 1'b1; cmd = 2'b11; wdata = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ssn", SS_n, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rdata", rdata, 8'h00);
    chk("mid_rst_mosi", MOSI, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 25; j++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    chk("no_done_after_abort", done_seen, 1'b0);
    run_frame('{2'b11, 8'h00, 0, 8'hC3, 19 + RD_LAT});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
